// File: rtl/switch_pkg.sv
// Shared definitions for the pushbutton conditioner: repeat FSM encoding,
// default timing constants and a counter-width helper.
package switch_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Defaults assume a 25 MHz clock: 10 ms debounce, 500 ms first repeat, 100 ms period.
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int DEFAULT_REPEAT_DELAY   = 12500000;
  localparam int DEFAULT_REPEAT_PERIOD  = 2500000;

  // Width of a counter that only ever needs to reach limit-1 (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/switch_channel.sv
// One pushbutton: 2-flop synchronizer, counter debounce, press pulse and
// auto-repeat FSM. All outputs are registered.
module switch_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic switch_raw,
  output logic switch_level,
  output logic switch_press,
  output logic switch_repeat
);

  localparam int DW = cnt_width(DEBOUNCE_LIMIT);
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_r;
  logic          stable_r;
  logic [DW-1:0] deb_cnt_r;
  rpt_state_e    state_r;
  rpt_state_e    state_s;
  logic [RW-1:0] rpt_cnt_r;
  logic [RW-1:0] rpt_cnt_s;
  logic          press_s;
  logic          repeat_s;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], switch_raw};
    end
  end

  // Debounce: the stable level flips only after DEBOUNCE_LIMIT consecutive differing clocks
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      stable_r  <= 1'b0;
      deb_cnt_r <= '0;
    end else if (sync_r[1] != stable_r) begin
      if (deb_cnt_r == DEB_MAX) begin
        stable_r  <= ~stable_r;
        deb_cnt_r <= '0;
      end else begin
        deb_cnt_r <= deb_cnt_r + DW'(1);
      end
    end else begin
      deb_cnt_r <= '0;
    end
  end

  // The previous registered level tells us which clock is the first one at 1
  assign press_s = stable_r & ~switch_level;

  // Repeat FSM state register
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r   <= RPT_IDLE;
      rpt_cnt_r <= '0;
    end else begin
      state_r   <= state_s;
      rpt_cnt_r <= rpt_cnt_s;
    end
  end

  // Repeat FSM next state; a debounced release wins over any due pulse
  always_comb begin
    state_s   = state_r;
    rpt_cnt_s = rpt_cnt_r;
    case (state_r)
      RPT_IDLE: begin
        rpt_cnt_s = '0;
        if (press_s) begin
          state_s = RPT_DELAY;
        end else begin
          state_s = RPT_IDLE;
        end
      end
      RPT_DELAY: begin
        if (!stable_r) begin
          state_s   = RPT_IDLE;
          rpt_cnt_s = '0;
        end else if (rpt_cnt_r == DLY_MAX) begin
          state_s   = RPT_REPEAT;
          rpt_cnt_s = '0;
        end else begin
          rpt_cnt_s = rpt_cnt_r + RW'(1);
        end
      end
      RPT_REPEAT: begin
        if (!stable_r) begin
          state_s   = RPT_IDLE;
          rpt_cnt_s = '0;
        end else if (rpt_cnt_r == PER_MAX) begin
          rpt_cnt_s = '0;
        end else begin
          rpt_cnt_s = rpt_cnt_r + RW'(1);
        end
      end
      default: begin
        state_s   = RPT_IDLE;
        rpt_cnt_s = '0;
      end
    endcase
  end

  // Repeat FSM output decode
  always_comb begin
    repeat_s = 1'b0;
    case (state_r)
      RPT_DELAY:  repeat_s = stable_r && (rpt_cnt_r == DLY_MAX);
      RPT_REPEAT: repeat_s = stable_r && (rpt_cnt_r == PER_MAX);
      default:    repeat_s = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      switch_level  <= 1'b0;
      switch_press  <= 1'b0;
      switch_repeat <= 1'b0;
    end else begin
      switch_level  <= stable_r;
      switch_press  <= press_s;
      switch_repeat <= repeat_s;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Four independent pushbutton channels: debounced level, press pulse and
// auto-repeat pulse per button; bit n-1 of each output belongs to i_Switch_n.
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Switch_Level,
  output logic [3:0] o_Switch_Press,
  output logic [3:0] o_Switch_Repeat
);

  logic [3:0] raw_s;

  assign raw_s = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    switch_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .i_Clk         (i_Clk),
      .i_Rst_L       (i_Rst_L),
      .switch_raw    (raw_s[ch]),
      .switch_level  (o_Switch_Level[ch]),
      .switch_press  (o_Switch_Press[ch]),
      .switch_repeat (o_Switch_Repeat[ch])
    );
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with short timing constants.
// Edge 0 is the first rising edge that samples a new switch value.
module tb_switch_conditioner;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] lvl;
  logic [3:0] prs;
  logic [3:0] rpt;
  logic [11:0] obs;
  logic [11:0] exp_v;
  int         checks = 0;
  int         passed = 0;

  switch_conditioner #(
    .DEBOUNCE_LIMIT (4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_l),
    .i_Switch_1      (sw[0]),
    .i_Switch_2      (sw[1]),
    .i_Switch_3      (sw[2]),
    .i_Switch_4      (sw[3]),
    .o_Switch_Level  (lvl),
    .o_Switch_Press  (prs),
    .o_Switch_Repeat (rpt)
  );

  always #5 clk = ~clk;

  assign obs = {lvl, prs, rpt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_l = 1'b0;
    sw    = 4'b0000;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    sw    = 4'b1111;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (obs !== 12'h000)
        $display("FAIL reset edge %0d: got %b expected %b", e, obs, 12'h000);
      else
        passed++;
    end
  endtask

  task automatic test_single_press();
    apply_reset();
    for (int e = 0; e < 16; e++) begin
      sw = 4'b0001;
      tick();
      exp_v = {(e >= 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000, 4'b0000};
      checks++;
      if (obs !== exp_v)
        $display("FAIL single_press edge %0d: got %b expected %b", e, obs, exp_v);
      else
        passed++;
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    for (int e = 0; e < 21; e++) begin
      sw = (e < 3) ? 4'b0010 : 4'b0000;
      tick();
      checks++;
      if (obs !== 12'h000)
        $display("FAIL glitch edge %0d: got %b expected %b", e, obs, 12'h000);
      else
        passed++;
    end
  endtask

  // Release sampled at edge 27 reaches the level output at edge 33.
  task automatic test_repeat();
    apply_reset();
    for (int e = 0; e < 46; e++) begin
      sw = (e < 27) ? 4'b0100 : 4'b0000;
      tick();
      exp_v = {(e >= 6 && e < 33) ? 4'b0100 : 4'b0000,
               (e == 6) ? 4'b0100 : 4'b0000,
               (e >= 16 && e <= 31 && ((e - 16) % 3) == 0) ? 4'b0100 : 4'b0000};
      checks++;
      if (obs !== exp_v)
        $display("FAIL repeat edge %0d: got %b expected %b", e, obs, exp_v);
      else
        passed++;
    end
  endtask

  // Level falls at edge 16, exactly when the first repeat would be due.
  task automatic test_release_due();
    apply_reset();
    for (int e = 0; e < 31; e++) begin
      sw = (e < 10) ? 4'b1000 : 4'b0000;
      tick();
      exp_v = {(e >= 6 && e < 16) ? 4'b1000 : 4'b0000, (e == 6) ? 4'b1000 : 4'b0000, 4'b0000};
      checks++;
      if (obs !== exp_v)
        $display("FAIL release_due edge %0d: got %b expected %b", e, obs, exp_v);
      else
        passed++;
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int e = 0; e < 9; e++) begin
      sw = 4'b1111;
      tick();
      exp_v = {(e >= 6) ? 4'b1111 : 4'b0000, (e == 6) ? 4'b1111 : 4'b0000, 4'b0000};
      checks++;
      if (obs !== exp_v)
        $display("FAIL simultaneous edge %0d: got %b expected %b", e, obs, exp_v);
      else
        passed++;
    end
  endtask

  task automatic test_reset_mid_delay();
    apply_reset();
    sw = 4'b0001;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp_v = {(e >= 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000, 4'b0000};
      checks++;
      if (obs !== exp_v)
        $display("FAIL mid_delay_pre edge %0d: got %b expected %b", e, obs, exp_v);
      else
        passed++;
    end
    rst_l = 1'b0;
    tick();
    checks++;
    if (obs !== 12'h000)
      $display("FAIL mid_delay_rst: got %b expected %b", obs, 12'h000);
    else
      passed++;
    rst_l = 1'b1;
    // Old timeline would have repeated at new edge 5; the fresh one repeats at 16.
    for (int e = 0; e < 18; e++) begin
      tick();
      exp_v = {(e >= 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000,
               (e == 16) ? 4'b0001 : 4'b0000};
      checks++;
      if (obs !== exp_v)
        $display("FAIL mid_delay_post edge %0d: got %b expected %b", e, obs, exp_v);
      else
        passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_release_due();
    test_simultaneous();
    test_reset_mid_delay();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
